uart_rx_os: RTL and testbench

- Parametrised oversampling UART receiver; next generation of the receive path.
- Recovers frames from the async serial line RX_IN using an external oversample tick (baud x OVERSAMPLE).
- Data width, parity mode and stop-bit count are configurable.
- Adds reset, a start-bit glitch reject, a valid strobe, sticky error flags and break detection. Sits between the pin and the host register/FIFO.

---
 rtl/uart_rx_os.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver. Recovers frames from the async line
//            RX_IN using an external oversample tick (baud x OVERSAMPLE).
//            Start-bit glitch reject, one-cycle valid strobe, held parity /
//            stop error flags and line-break detection.
// Ports    : RX_CLK            system clock, rising edge
//            RX_RST            asynchronous active-high reset
//            RX_TICK           oversample enable, one RX_CLK cycle wide
//            RX_IN             async serial line, idle high
//            RX_DATA           data of the last frame without a stop error
//            RX_VALID          one-cycle strobe at frame end
//            PARITY_BIT_ERROR  parity result of the last frame
//            STOP_BIT_ERROR    stop result of the last frame
//            RX_BREAK          high while the line stays low after a stop error
//            RX_BUSY           high whenever the FSM is not idle
// Options  : UART_RX_MAJORITY_VOTE_EN - 2-of-3 majority vote around mid-bit
//            for every bit (start, data, parity, stop).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_WIDTH  = 8,   // 5..9 data bits, LSB first
    parameter int OVERSAMPLE  = 16,  // ticks per bit, even, >= 8
    parameter int PARITY_MODE = 1,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS   = 1    // 1 or 2
) (
    input  logic                  RX_CLK,
    input  logic                  RX_RST,
    input  logic                  RX_TICK,
    input  logic                  RX_IN,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  PARITY_BIT_ERROR,
    output logic                  STOP_BIT_ERROR,
    output logic                  RX_BREAK,
    output logic                  RX_BUSY
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_WIDTH + 1);

    localparam logic [c_TW-1:0] c_CNT_MAX = c_TW'(OVERSAMPLE - 1);

    // Decision tick inside the start bit. With voting the decision moves to
    // the last of the three vote ticks; the counter is cleared there, so all
    // following bits decide at c_CNT_MAX, exactly one bit period later.
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [c_TW-1:0] c_START_DEC = c_TW'(OVERSAMPLE / 2);
`else
    localparam logic [c_TW-1:0] c_START_DEC = c_TW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [c_TW-1:0] c_BIT_DEC   = c_CNT_MAX;

    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_WIDTH - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
    localparam logic            c_HAS_PAR   = (PARITY_MODE != 0);
    localparam logic            c_ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  r_sync1;
    logic                  r_sync2;
    state_t                r_state;
    logic [c_TW-1:0]       r_tick_cnt;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_pend;   // parity result of the frame in flight
    logic                  r_stop_acc;   // stop error seen in an earlier stop bit
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_serr;

    // ------------------------------------------------------------------
    // Next-state / datapath wires
    // ------------------------------------------------------------------
    state_t                w_state_n;
    logic [c_TW-1:0]       w_tick_cnt_n;
    logic [c_BW-1:0]       w_bit_cnt_n;
    logic [DATA_WIDTH-1:0] w_shift_n;
    logic                  w_par_pend_n;
    logic                  w_stop_acc_n;
    logic [DATA_WIDTH-1:0] w_data_n;
    logic                  w_valid_n;
    logic                  w_perr_n;
    logic                  w_serr_n;

    logic                  w_rxs;
    logic                  w_bit;
    logic [c_TW-1:0]       w_cnt_inc;
    logic [c_TW-1:0]       w_dec_pt;
    logic                  w_at_dec;
    logic                  w_serr_now;

    assign w_rxs     = r_sync2;
    assign w_cnt_inc = (r_tick_cnt == c_CNT_MAX) ? '0 : r_tick_cnt + c_TW'(1);
    assign w_dec_pt  = (r_state == S_START) ? c_START_DEC : c_BIT_DEC;
    assign w_at_dec  = RX_TICK && (r_tick_cnt == w_dec_pt);
    assign w_serr_now = r_stop_acc | ~w_bit;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, reset to the idle line level
    // ------------------------------------------------------------------
    always_ff @(posedge RX_CLK or posedge RX_RST) begin
        if (RX_RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Bit decision: single mid-bit sample or 2-of-3 vote
    // ------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;

    // Capture the two samples preceding the decision tick; the third vote
    // is the live synchronised value on the decision tick itself.
    always_ff @(posedge RX_CLK or posedge RX_RST) begin
        if (RX_RST) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else if (RX_TICK) begin
            if (r_tick_cnt == w_dec_pt - c_TW'(2)) begin
                r_vote0 <= w_rxs;
            end
            if (r_tick_cnt == w_dec_pt - c_TW'(1)) begin
                r_vote1 <= w_rxs;
            end
        end
    end

    assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & w_rxs) | (r_vote1 & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge RX_CLK or posedge RX_RST) begin
        if (RX_RST) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_pend <= 1'b0;
            r_stop_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_tick_cnt <= w_tick_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            r_par_pend <= w_par_pend_n;
            r_stop_acc <= w_stop_acc_n;
            r_data     <= w_data_n;
            r_valid    <= w_valid_n;
            r_perr     <= w_perr_n;
            r_serr     <= w_serr_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_tick_cnt_n = r_tick_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_par_pend_n = r_par_pend;
        w_stop_acc_n = r_stop_acc;
        w_data_n     = r_data;
        w_valid_n    = 1'b0;
        w_perr_n     = r_perr;
        w_serr_n     = r_serr;

        case (r_state)
            S_IDLE: begin
                if (RX_TICK && !w_rxs) begin
                    w_state_n    = S_START;
                    w_tick_cnt_n = '0;
                end
            end

            S_START: begin
                if (RX_TICK) begin
                    if (w_at_dec) begin
                        // Clearing here puts every later decision one full
                        // bit period on, i.e. at mid-bit.
                        w_tick_cnt_n = '0;
                        if (w_bit) begin
                            w_state_n = S_IDLE;      // false start
                        end else begin
                            w_state_n    = S_DATA;
                            w_bit_cnt_n  = '0;
                            w_par_pend_n = 1'b0;
                        end
                    end else begin
                        w_tick_cnt_n = w_cnt_inc;
                    end
                end
            end

            S_DATA: begin
                if (RX_TICK) begin
                    w_tick_cnt_n = w_cnt_inc;
                    if (w_at_dec) begin
                        w_shift_n = {w_bit, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_LAST_DATA) begin
                            w_bit_cnt_n  = '0;
                            w_stop_acc_n = 1'b0;
                            w_state_n    = c_HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_cnt_n = r_bit_cnt + c_BW'(1);
                        end
                    end
                end
            end

            S_PARITY: begin
                if (RX_TICK) begin
                    w_tick_cnt_n = w_cnt_inc;
                    if (w_at_dec) begin
                        w_par_pend_n = ((^r_shift) ^ w_bit) != c_ODD;
                        w_state_n    = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (RX_TICK) begin
                    w_tick_cnt_n = w_cnt_inc;
                    if (w_at_dec) begin
                        if (r_bit_cnt == c_LAST_STOP) begin
                            // Frame end: results become visible next cycle.
                            w_valid_n    = 1'b1;
                            w_perr_n     = r_par_pend;
                            w_serr_n     = w_serr_now;
                            w_bit_cnt_n  = '0;
                            w_tick_cnt_n = '0;
                            w_stop_acc_n = 1'b0;
                            if (!w_serr_now) begin
                                w_data_n = r_shift;
                            end
                            w_state_n = (w_serr_now && !w_rxs) ? S_BREAK : S_IDLE;
                        end else begin
                            w_stop_acc_n = w_serr_now;
                            w_bit_cnt_n  = r_bit_cnt + c_BW'(1);
                        end
                    end
                end
            end

            S_BREAK: begin
                if (RX_TICK && w_rxs) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RX_DATA          = r_data;
    assign RX_VALID         = r_valid;
    assign PARITY_BIT_ERROR = r_perr;
    assign STOP_BIT_ERROR   = r_serr;
    assign RX_BREAK         = (r_state == S_BREAK);
    assign RX_BUSY          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Self-checking bench for uart_rx_os. Instance 0 runs 8E1,
//            instance 1 runs 7O2; both use OVERSAMPLE = 16 and a tick every
//            4 clocks. Directed frames with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx0;
    logic       rx1;

    logic [7:0] d0;
    logic       v0, pe0, se0, brk0, busy0;
    logic [6:0] d1;
    logic       v1, pe1, se1, brk1, busy1;

    int n_chk  = 0;
    int n_pass = 0;

    int vcnt0 = 0;
    int vcnt1 = 0;
    int dbl   = 0;
    logic [8:0] cap1 [0:3];

    always #5 clk = ~clk;

    uart_rx_os #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .PARITY_MODE(1),
        .STOP_BITS  (1)
    ) u_dut0 (
        .RX_CLK          (clk),
        .RX_RST          (rst),
        .RX_TICK         (tick),
        .RX_IN           (rx0),
        .RX_DATA         (d0),
        .RX_VALID        (v0),
        .PARITY_BIT_ERROR(pe0),
        .STOP_BIT_ERROR  (se0),
        .RX_BREAK        (brk0),
        .RX_BUSY         (busy0)
    );

    uart_rx_os #(
        .DATA_WIDTH (7),
        .OVERSAMPLE (16),
        .PARITY_MODE(2),
        .STOP_BITS  (2)
    ) u_dut1 (
        .RX_CLK          (clk),
        .RX_RST          (rst),
        .RX_TICK         (tick),
        .RX_IN           (rx1),
        .RX_DATA         (d1),
        .RX_VALID        (v1),
        .PARITY_BIT_ERROR(pe1),
        .STOP_BIT_ERROR  (se1),
        .RX_BREAK        (brk1),
        .RX_BUSY         (busy1)
    );

    // Oversample tick: one clock high out of every four.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Valid-strobe monitor: counts pulses, flags any pulse wider than one
    // cycle, records instance-1 results at each strobe.
    initial begin
        logic p0;
        logic p1;
        p0 = 1'b0;
        p1 = 1'b0;
        forever begin
            @(negedge clk);
            if (v0) vcnt0++;
            if (v0 && p0) dbl++;
            if (v1 && p1) dbl++;
            if (v1) begin
                if (vcnt1 < 4) cap1[vcnt1] = {se1, pe1, d1};
                vcnt1++;
            end
            p0 = v0;
            p1 = v1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    // Drive n bits (bit 0 first), each one bit period long, aligned to a tick.
    task automatic send(input int line, input logic [31:0] bits, input int n);
        wait_ticks(1);
        #1;
        for (int i = 0; i < n; i++) begin
            if (line == 0) rx0 = bits[i];
            else           rx1 = bits[i];
            wait_ticks(16);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data0",  d0,    32'h0);
        check("rst_valid0", v0,    32'h0);
        check("rst_perr0",  pe0,   32'h0);
        check("rst_serr0",  se0,   32'h0);
        check("rst_brk0",   brk0,  32'h0);
        check("rst_busy0",  busy0, 32'h0);
        check("rst_data1",  d1,    32'h0);
        rst = 1'b0;
        wait_ticks(4);

        // Good frame 0xA5, even parity 0, stop 1
        send(0, {21'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        check("a5_count", vcnt0, 32'd1);
        check("a5_data",  d0,    32'hA5);
        check("a5_perr",  pe0,   32'h0);
        check("a5_serr",  se0,   32'h0);
        check("a5_busy",  busy0, 32'h0);

        // 0x3C with wrong parity bit 1
        send(0, {21'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        check("3c_count", vcnt0, 32'd2);
        check("3c_perr",  pe0,   32'h1);
        check("3c_data",  d0,    32'h3C);
        check("3c_serr",  se0,   32'h0);

        // Good 0x01 (parity 1) clears the parity flag
        send(0, {21'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        check("01_count", vcnt0, 32'd3);
        check("01_perr",  pe0,   32'h0);
        check("01_data",  d0,    32'h01);

        // 0x55 with stop forced low, line held low 40 bit times
        send(0, {21'b0, 1'b0, 1'b0, 8'h55, 1'b0}, 11);
        wait_ticks(40 * 16);
        #1;
        check("brk_count", vcnt0, 32'd4);
        check("brk_serr",  se0,   32'h1);
        check("brk_data",  d0,    32'h01);
        check("brk_flag",  brk0,  32'h1);
        check("brk_busy",  busy0, 32'h1);
        rx0 = 1'b1;
        wait_ticks(4);
        #1;
        check("brk_exit",  brk0,  32'h0);
        check("brk_idle",  busy0, 32'h0);
        send(0, {21'b0, 1'b1, 1'b0, 8'h12, 1'b0}, 11);
        check("12_count", vcnt0, 32'd5);
        check("12_data",  d0,    32'h12);
        check("12_serr",  se0,   32'h0);
        check("12_perr",  pe0,   32'h0);

        // Low glitch of 3 ticks on the idle line
        wait_ticks(1);
        #1;
        rx0 = 1'b0;
        wait_ticks(3);
        #1;
        rx0 = 1'b1;
        wait_ticks(1);
        #1;
        check("gl_busy_hi", busy0, 32'h1);
        wait_ticks(6);
        #1;
        check("gl_busy_lo", busy0, 32'h0);
        check("gl_count",   vcnt0, 32'd5);
        check("gl_data",    d0,    32'h12);
        check("gl_perr",    pe0,   32'h0);
        check("gl_serr",    se0,   32'h0);

        // 7O2 back-to-back: 0x7F (parity 0) then 0x00 (parity 1), no idle
        send(1, {10'b0,
                 2'b11, 1'b1, 7'h00, 1'b0,
                 2'b11, 1'b0, 7'h7F, 1'b0}, 22);
        wait_ticks(2);
        #1;
        check("b2b_count", vcnt1,   32'd2);
        check("b2b_f0",    cap1[0], 32'h07F);
        check("b2b_f1",    cap1[1], 32'h000);
        check("b2b_data",  d1,      32'h00);
        check("b2b_busy",  busy1,   32'h0);

        // Reset during the 4th data bit of 0x81
        send(0, {28'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 4);
        rx0 = 1'b0;
        wait_ticks(8);
        #1;
        rst = 1'b1;
        #1;
        check("mr_data",  d0,    32'h0);
        check("mr_valid", v0,    32'h0);
        check("mr_perr",  pe0,   32'h0);
        check("mr_serr",  se0,   32'h0);
        check("mr_busy",  busy0, 32'h0);
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(4);
        check("mr_count", vcnt0, 32'd5);
        send(0, {21'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11);
        check("81_count", vcnt0, 32'd6);
        check("81_data",  d0,    32'h81);
        check("81_perr",  pe0,   32'h0);
        check("81_serr",  se0,   32'h0);

        check("valid_width", dbl, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
